// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: direct-mapped cache controller FSM (CPU req in, cache w/wsel/rsel/word_idx + mem strobe/mrw out, hit/miss stats)
module cache_ctrl_fsm #(
  parameter int MEM_LAT = 4,
  parameter int LINE_WORDS = 4,
  parameter int WRITE_ALLOC = 0,
  parameter int CNT_W = 16,
  localparam int IW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1,
  localparam int CW = $clog2(MEM_LAT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe,
  input  logic             rw,
  input  logic [IW-1:0]    req_word,
  input  logic             match,
  input  logic             valid,
  output logic             rdy,
  output logic             busy,
  output logic             w,
  output logic             wsel,
  output logic             rsel,
  output logic             mstrobe,
  output logic             mrw,
  output logic [IW-1:0]    word_idx,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  typedef enum logic [3:0] {
    IDLE, LOOKUP, RD_MISS, RD_MEM, FILL, RD_DATA, WR_MEM, WR_WAIT, WR_ALLOC, WR_MERGE, WR_DATA
  } state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] fidx, fidx_n, req_q, req_n;
  logic rw_q, rw_n, hit_q, hit_n, last;
  assign last = fidx == IW'(LINE_WORDS - 1);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    fidx_n = fidx;
    req_n = req_q;
    rw_n = rw_q;
    hit_n = hit_q;
    case (state)
      IDLE: if (strobe) begin
        state_n = LOOKUP;
        rw_n = rw;
        req_n = req_word;
      end
      LOOKUP: begin
        hit_n = match & valid;
        state_n = rw_q ? WR_MEM : hit_n ? RD_DATA : RD_MISS;
      end
      RD_MISS, WR_MEM, WR_ALLOC: begin
        cnt_n = CW'(MEM_LAT);
        state_n = (state == WR_MEM) ? WR_WAIT : RD_MEM;
      end
      RD_MEM, WR_WAIT: begin
        cnt_n = cnt - CW'(cnt != '0);
        if (cnt <= CW'(1))
          state_n = (state == RD_MEM) ? FILL : (!hit_q && WRITE_ALLOC != 0) ? WR_ALLOC : WR_DATA;
      end
      FILL: begin
        fidx_n = last ? '0 : fidx + IW'(1);
        if (last) state_n = rw_q ? WR_MERGE : RD_DATA;
      end
      WR_MERGE: state_n = WR_DATA;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      fidx <= '0;
      req_q <= '0;
      rw_q <= 1'b0;
      hit_q <= 1'b0;
      {rdy, busy, w, wsel, rsel, mstrobe, mrw} <= '0;
      word_idx <= '0;
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      fidx <= fidx_n;
      req_q <= req_n;
      rw_q <= rw_n;
      hit_q <= hit_n;
      rdy <= state_n == RD_DATA || state_n == WR_DATA;
      busy <= state_n != IDLE;
      w <= state_n == FILL || state_n == WR_MERGE || (state_n == WR_MEM && hit_n);
      wsel <= state_n == FILL;
      rsel <= state_n == RD_DATA && !hit_n;
      mstrobe <= state_n inside {RD_MISS, WR_MEM, WR_ALLOC};
      mrw <= state_n == WR_MEM;
      word_idx <= (state_n == FILL) ? fidx_n : (state_n == WR_MEM || state_n == WR_MERGE) ? req_n : '0;
      if (state == LOOKUP && hit_n) hit_cnt <= hit_cnt + CNT_W'(hit_cnt != '1);
      if (state == LOOKUP && !hit_n) miss_cnt <= miss_cnt + CNT_W'(miss_cnt != '1);
    end
  end
endmodule
